// File: rtl/hex_scroll_display.sv
// Digit FIFO feeding a six-slot right-to-left scroller for the DE-series HEX5..HEX0 displays.
// After the FIFO empties, blanks are shifted in until the display is clear, then the block idles.
module hex_scroll_display #(
    parameter int unsigned TICK_COUNT = 25_000_000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    input  logic       scroll_en,
    output logic       busy,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;
    localparam int unsigned CntW  = $clog2(TICK_COUNT);
    localparam logic [CntW-1:0] TickLast = CntW'(TICK_COUNT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [2:0]          blank_q;
    logic [PtrW-1:0]     wr_ptr_q;
    logic [PtrW-1:0]     rd_ptr_q;
    logic [3:0]          mem_q [FIFO_DEPTH];
    logic [5:0]          slot_vld_q;
    logic [5:0][3:0]     slot_dig_q;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic tick;

    // Extra pointer MSB distinguishes full from empty when the address bits match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign in_ready = resetn && !full;
    assign push     = in_valid && in_ready;
    assign tick     = (state_q != StIdle) && scroll_en && (cnt_q == TickLast);
    assign pop      = tick && !empty;
    assign busy     = (state_q != StIdle);

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            blank_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            slot_vld_q <= '0;
            slot_dig_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (tick) begin
                slot_vld_q <= {slot_vld_q[4:0], !empty};
                slot_dig_q <= {slot_dig_q[4:0], empty ? 4'h0 : mem_q[rd_ptr_q[AddrW-1:0]]};
            end
            if ((state_q != StIdle) && scroll_en) begin
                cnt_q <= (cnt_q == TickLast) ? '0 : cnt_q + CntW'(1);
            end

            case (state_q)
                StIdle: begin
                    if (!empty) begin
                        state_q <= StRun;
                        cnt_q   <= '0;
                    end
                end
                StRun: begin
                    if (tick && empty) begin
                        state_q <= StDrain;
                        blank_q <= 3'd1;
                    end
                end
                StDrain: begin
                    if (tick) begin
                        if (!empty) begin
                            state_q <= StRun;
                            blank_q <= '0;
                        end else if (blank_q == 3'd5) begin
                            // Sixth blank clears the last visible digit.
                            state_q <= StIdle;
                            blank_q <= '0;
                        end else begin
                            blank_q <= blank_q + 3'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    function automatic logic [6:0] seg7(input logic vld, input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return vld ? s : 7'h7F;
    endfunction

    assign HEX0 = seg7(slot_vld_q[0], slot_dig_q[0]);
    assign HEX1 = seg7(slot_vld_q[1], slot_dig_q[1]);
    assign HEX2 = seg7(slot_vld_q[2], slot_dig_q[2]);
    assign HEX3 = seg7(slot_vld_q[3], slot_dig_q[3]);
    assign HEX4 = seg7(slot_vld_q[4], slot_dig_q[4]);
    assign HEX5 = seg7(slot_vld_q[5], slot_dig_q[5]);

endmodule

// File: tb/tb_hex_scroll_display.sv
// Bench for hex_scroll_display: directed scenarios plus a randomized run, all against a
// queue-based model of the scroller kept in this file.
module tb_hex_scroll_display;

    localparam int TICK  = 4;
    localparam int DEPTH = 8;
    localparam logic [41:0] AllBlank = {6{7'h7F}};

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       scroll_en;
    logic       busy;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [41:0] hex_bus;

    int total = 0;
    int bad   = 0;

    assign hex_bus = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    always #5 CLOCK_50 = ~CLOCK_50;

    hex_scroll_display #(
        .TICK_COUNT(TICK),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .scroll_en(scroll_en),
        .busy     (busy),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5)
    );

    // Reference model: a digit queue, six display cells (-1 = blank), an activity mode
    // (0 idle, 1 scrolling digits, 2 scrolling blanks) and a step timer.
    int m_q[$];
    int m_disp[6];
    int m_mode   = 0;
    int m_phase  = 0;
    int m_blanks = 0;
    int m_ticks  = 0;
    bit m_had;
    bit m_fire;
    bit m_acc;

    initial begin
        for (int k = 0; k < 6; k++) m_disp[k] = -1;
    end

    always @(posedge CLOCK_50) begin
        if (!resetn) begin
            m_q.delete();
            for (int k = 0; k < 6; k++) m_disp[k] = -1;
            m_mode   = 0;
            m_phase  = 0;
            m_blanks = 0;
        end else begin
            m_acc  = in_valid && (m_q.size() < DEPTH);
            m_had  = (m_q.size() > 0);
            m_fire = (m_mode != 0) && scroll_en && (m_phase == TICK - 1);
            if (m_mode == 0) begin
                if (m_had) begin
                    m_mode  = 1;
                    m_phase = 0;
                end
            end else begin
                if (scroll_en) m_phase = (m_phase + 1) % TICK;
                if (m_fire) begin
                    m_ticks++;
                    for (int k = 5; k > 0; k--) m_disp[k] = m_disp[k-1];
                    if (m_had) begin
                        m_disp[0] = m_q.pop_front();
                        m_mode    = 1;
                        m_blanks  = 0;
                    end else begin
                        m_disp[0] = -1;
                        m_blanks++;
                        m_mode = (m_blanks == 6) ? 0 : 2;
                        if (m_mode == 0) m_blanks = 0;
                    end
                end
            end
            if (m_acc) m_q.push_back(int'(in_data));
        end
    end

    function automatic logic [6:0] font(input int d);
        case (d)
            0:  return 7'h40;
            1:  return 7'h79;
            2:  return 7'h24;
            3:  return 7'h30;
            4:  return 7'h19;
            5:  return 7'h12;
            6:  return 7'h02;
            7:  return 7'h78;
            8:  return 7'h00;
            9:  return 7'h10;
            10: return 7'h08;
            11: return 7'h03;
            12: return 7'h46;
            13: return 7'h21;
            14: return 7'h06;
            15: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [41:0] exp_bus();
        logic [41:0] r;
        for (int k = 0; k < 6; k++) r[k*7 +: 7] = font(m_disp[k]);
        return r;
    endfunction

    task automatic cyc();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (m_mode != 0 && n < 200) begin
            cyc();
            n++;
        end
        total++;
        if (busy !== 1'b0 || m_mode != 0) begin
            bad++;
            $display("FAIL %s_idle busy=%b want=0 after %0d cycles", name, busy, n);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; in_valid = 1'b1; in_data = 4'h5; scroll_en = 1'b1;
        repeat (3) begin
            cyc();
            total++;
            if (in_ready !== 1'b0) begin
                bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready);
            end
            total++;
            if (busy !== 1'b0) begin
                bad++; $display("FAIL reset_busy got=%b want=0", busy);
            end
            total++;
            if (hex_bus !== AllBlank) begin
                bad++; $display("FAIL reset_hex got=%h want=%h", hex_bus, AllBlank);
            end
        end
        resetn = 1'b1; in_valid = 1'b0;
        cyc();
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL release_in_ready got=%b want=1", in_ready);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL release_busy got=%b want=0 (digit taken in reset)", busy);
        end
    endtask

    task automatic test_short_burst();
        int base = m_ticks;
        scroll_en = 1'b1;
        in_valid = 1'b1; in_data = 4'h1; cyc();
        in_data = 4'h2; cyc();
        in_data = 4'h3; cyc();
        in_valid = 1'b0;
        // First digit lands TICK edges after the edge that left idle.
        cyc(); cyc();
        total++;
        if (HEX0 !== 7'h7F) begin
            bad++; $display("FAIL burst_early HEX0 got=%h want=7f", HEX0);
        end
        cyc();
        total++;
        if (HEX0 !== 7'h79) begin
            bad++; $display("FAIL burst_first HEX0 got=%h want=79", HEX0);
        end
        for (int i = 0; i < 100 && m_ticks < base + 3; i++) begin
            cyc();
            total++;
            if (hex_bus !== exp_bus()) begin
                bad++; $display("FAIL burst_model got=%h want=%h", hex_bus, exp_bus());
            end
        end
        total++;
        if (hex_bus[20:0] !== {7'h79, 7'h24, 7'h30}) begin
            bad++; $display("FAIL burst_tick3 got=%h want=792430", hex_bus[20:0]);
        end
        for (int i = 0; i < 100 && m_ticks < base + 9; i++) begin
            cyc();
            total++;
            if (busy !== (m_mode != 0)) begin
                bad++; $display("FAIL burst_busy got=%b want=%b", busy, m_mode != 0);
            end
        end
        total++;
        if (hex_bus !== AllBlank || busy !== 1'b0) begin
            bad++; $display("FAIL burst_tick9 hex=%h busy=%b want=%h busy=0", hex_bus, busy, AllBlank);
        end
    endtask

    task automatic test_overflow();
        int exp_d[$];
        int pop_edge = -1;
        int acc_edge = -1;
        int idx = 0;
        int pre;
        bit acc_now;
        scroll_en = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            in_data = 4'($urandom_range(0, 15));
            exp_d.push_back(int'(in_data));
            cyc();
        end
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL ovf_full_ready got=%b want=0", in_ready);
        end
        in_data = 4'h9; exp_d.push_back(9); scroll_en = 1'b1;
        for (int i = 0; i < 300 && idx < 9; i++) begin
            total++;
            if (in_ready !== (resetn && m_q.size() < DEPTH)) begin
                bad++; $display("FAIL ovf_ready got=%b want=%b", in_ready, m_q.size() < DEPTH);
            end
            acc_now = in_valid && in_ready;
            pre = m_ticks;
            cyc();
            if (acc_now) begin
                acc_edge = i;
                in_valid = 1'b0;
            end
            if (m_ticks != pre) begin
                if (pop_edge < 0) pop_edge = i;
                total++;
                if (HEX0 !== font(exp_d[idx])) begin
                    bad++; $display("FAIL ovf_order idx=%0d got=%h want=%h", idx, HEX0,
                                    font(exp_d[idx]));
                end
                idx++;
            end
        end
        total++;
        if (idx != 9) begin
            bad++; $display("FAIL ovf_count got=%0d want=9 digits", idx);
        end
        total++;
        if (acc_edge != pop_edge + 1) begin
            bad++; $display("FAIL ovf_accept_edge got=%0d want=%0d", acc_edge, pop_edge + 1);
        end
        wait_idle("ovf");
    endtask

    task automatic test_wrap_off();
        int base = m_ticks;
        scroll_en = 1'b1;
        in_valid  = 1'b1;
        for (int d = 0; d < 7; d++) begin
            in_data = 4'(d);
            cyc();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 100 && m_ticks < base + 7; i++) cyc();
        total++;
        if (hex_bus !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}) begin
            bad++; $display("FAIL wrap_tick7 got=%h want=79 24 30 19 12 02", hex_bus);
        end
        wait_idle("wrap");
    endtask

    task automatic test_freeze();
        int d[4];
        int base = m_ticks;
        logic [41:0] snap;
        scroll_en = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d[i] = int'($urandom_range(0, 15));
            in_data = 4'(d[i]);
            cyc();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 100 && m_ticks < base + 1; i++) cyc();
        cyc();
        snap = hex_bus;
        scroll_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            total++;
            if (hex_bus !== snap) begin
                bad++; $display("FAIL freeze_hold cyc=%0d got=%h want=%h", i, hex_bus, snap);
            end
        end
        scroll_en = 1'b1;
        cyc(); cyc();
        total++;
        if (hex_bus !== snap) begin
            bad++; $display("FAIL freeze_early got=%h want=%h", hex_bus, snap);
        end
        cyc();
        total++;
        if (HEX0 !== font(d[1]) || HEX1 !== font(d[0])) begin
            bad++; $display("FAIL freeze_resume HEX1/0 got=%h %h want=%h %h", HEX1, HEX0,
                            font(d[0]), font(d[1]));
        end
        wait_idle("freeze");
    endtask

    task automatic test_refill_and_reset();
        int d = int'($urandom_range(0, 15));
        int base = m_ticks;
        int n = 0;
        scroll_en = 1'b1;
        in_valid = 1'b1; in_data = 4'(d); cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 100 && m_ticks < base + 3; i++) cyc();
        in_valid = 1'b1; in_data = 4'hA; cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 100 && m_ticks < base + 4; i++) cyc();
        total++;
        if (HEX0 !== 7'h08 || HEX3 !== font(d) || busy !== 1'b1) begin
            bad++; $display("FAIL refill_shift HEX0=%h HEX3=%h busy=%b want 08 %h 1", HEX0, HEX3,
                            busy, font(d));
        end
        // Back in digit mode, so a full six blanks are needed before idling.
        while (busy === 1'b1 && n < 100) begin
            cyc();
            n++;
        end
        total++;
        if (n != 6 * TICK) begin
            bad++; $display("FAIL refill_drain cycles got=%0d want=%0d", n, 6 * TICK);
        end
        base = m_ticks;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 4'($urandom_range(0, 15));
            cyc();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 100 && m_ticks < base + 1; i++) cyc();
        resetn = 1'b0;
        cyc();
        total++;
        if (hex_bus !== AllBlank || busy !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL midrun_reset hex=%h busy=%b rdy=%b want all 7f,0,0", hex_bus,
                            busy, in_ready);
        end
        resetn = 1'b1;
        cyc();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            in_valid  = ($urandom_range(0, 3) == 0);
            in_data   = 4'($urandom_range(0, 15));
            scroll_en = ($urandom_range(0, 7) != 0);
            resetn    = ($urandom_range(0, 299) != 0);
            cyc();
            total++;
            if (hex_bus !== exp_bus()) begin
                bad++; $display("FAIL rand_hex cyc=%0d got=%h want=%h", i, hex_bus, exp_bus());
            end
            total++;
            if (busy !== (m_mode != 0)) begin
                bad++; $display("FAIL rand_busy cyc=%0d got=%b want=%b", i, busy, m_mode != 0);
            end
            total++;
            if (in_ready !== (resetn && m_q.size() < DEPTH)) begin
                bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", i, in_ready,
                                resetn && m_q.size() < DEPTH);
            end
        end
        resetn = 1'b1; in_valid = 1'b0; scroll_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_short_burst();
        test_overflow();
        test_wrap_off();
        test_freeze();
        test_refill_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
